// File: rtl/half_adder_pkg.sv
// Shared defaults and helpers for the half_adder block.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // All-ones value of a w-bit counter (w in 1..32), used as the saturation ceiling.
  function automatic logic [31:0] sat_max(input int w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane: sum = a ^ b, carry = a & b.
module half_adder_cell (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with registered outputs (latency 1).
// Optional carry-event counter enabled by macro HALF_ADDER_STATS_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             any_carry
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_count
`endif
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             any_q, any_d;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
      half_adder_cell u_cell (
        .a_i     (a[gi]),
        .b_i     (b[gi]),
        .sum_o   (sum_c[gi]),
        .carry_o (carry_c[gi])
      );
    end
  endgenerate

  // Inputs are only looked at when in_valid is high, so X on idle cycles never propagates.
  always_comb begin
    valid_d = in_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
    any_d   = any_q;
    if (in_valid) begin
      sum_d   = sum_c;
      carry_d = carry_c;
      any_d   = |carry_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      any_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      any_q   <= any_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign any_carry = any_q;

`ifdef HALF_ADDER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|carry_c) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder at WIDTH=8, CNT_W=4 (counter checks need HALF_ADDER_STATS_EN).
module tb_half_adder;

  localparam int W   = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic [W-1:0]  sum;
  logic [W-1:0]  carry;
  logic          any_carry;
`ifdef HALF_ADDER_STATS_EN
  logic [CW-1:0] carry_count;
`endif

  half_adder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .any_carry (any_carry)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_count (carry_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         any;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          held;
  logic          exp_valid = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  bit            started = 1'b0;
  int            checks = 0;
  int            passes = 0;
  int            accepted = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample inputs on the same edge the DUT does.
  always @(posedge clk) begin
    if (!rst_n) begin
      started   = 1'b1;
      exp_valid = 1'b0;
      exp_cnt   = '0;
      held      = '0;
      sb_q.delete();
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        exp_t e;
        e.s   = a ^ b;
        e.c   = a & b;
        e.any = |(a & b);
        sb_q.push_back(e);
        accepted++;
        if (e.any && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  // Monitor: compare away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check_val("out_valid", 64'(out_valid), 64'(exp_valid));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_val("sb_empty", 64'(1), 64'(0));
        end else begin
          held = sb_q.pop_front();
          $display("txn: sum=%02h carry=%02h any=%0b", sum, carry, any_carry);
        end
      end
      check_val("sum", 64'(sum), 64'(held.s));
      check_val("carry", 64'(carry), 64'(held.c));
      check_val("any_carry", 64'(any_carry), 64'(held.any));
`ifdef HALF_ADDER_STATS_EN
      check_val("carry_count", 64'(carry_count), 64'(exp_cnt));
`endif
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic rn);
    @(posedge clk);
    #1;
    in_valid = v;
    a        = av;
    b        = bv;
    rst_n    = rn;
  endtask

  initial begin
    // Watchdog so the run always terminates.
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   pat;
    // Reset
    repeat (3) drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    // Truth table on lane 0, back to back
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      drive(1'b1, W'(pat[1]), W'(pat[0]), 1'b1);
    end
    // Capture 1+1, then hold while inputs wander (including X)
    drive(1'b1, W'(1), W'(1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      drive(1'b0, ra, rb, 1'b1);
    end
    drive(1'b0, 'x, 'x, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    // Independent lanes, low nibble
    drive(1'b1, W'(4'b1100), W'(4'b1010), 1'b1);
    drive(1'b1, W'(4'b0101), W'(4'b1010), 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    // Reset wins over a valid input
    drive(1'b1, '1, '1, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    // Counter saturation, then reset clears it
    for (int i = 0; i < 20; i++) drive(1'b1, '1, '1, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b1);
    // Randomized traffic until 1000 more inputs are accepted
    begin
      int target;
      target = accepted + 1000;
      while (accepted < target) begin
        ra = W'($urandom);
        rb = W'($urandom);
        drive(($urandom_range(3) != 0), ra, rb, 1'b1);
      end
    end
    repeat (3) drive(1'b0, '0, '0, 1'b1);
    @(posedge clk);
    check_val("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent half-adder lanes (legal range 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the carry-event counter (legal range 4..32).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-004 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-005 Port rst_n: input, 1 bit, synchronous active-low reset.
REQ-006 Port in_valid: input, 1 bit, qualifies a and b for capture this cycle.
REQ-007 Port a: input, WIDTH bits, addend A, one bit per lane.
REQ-008 Port b: input, WIDTH bits, addend B, one bit per lane.
REQ-009 Port out_valid: output, 1 bit, sum/carry hold a new result this cycle.
REQ-010 Port sum: output, WIDTH bits, registered per-lane sum.
REQ-011 Port carry: output, WIDTH bits, registered per-lane carry.
REQ-012 Port any_carry: output, 1 bit, registered OR-reduction of carry.

Function
REQ-013 Per lane i, the block SHALL compute sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]; lanes SHALL NOT interact (no ripple).
REQ-014 On a rising clk with rst_n=1 and in_valid=1, the block SHALL register sum, carry and any_carry from the current a/b, so the result is visible the cycle after capture (latency 1).
REQ-015 With rst_n=1 and in_valid=0, sum, carry and any_carry SHALL hold their previous values.
REQ-016 out_valid SHALL be in_valid registered one cycle (1 for exactly one cycle per accepted input); the block SHALL always accept input (no backpressure).
REQ-017 Back-to-back in_valid SHALL produce back-to-back results, one per cycle, in order.
REQ-018 X/Z on a or b while in_valid=0 SHALL NOT affect outputs.

Reset
REQ-019 While rst_n=0 at a rising clk, sum, carry, any_carry and out_valid SHALL become 0, and the counter, if present, SHALL become 0.
REQ-020 Reset SHALL take priority over in_valid; an input presented in the reset cycle SHALL be discarded.
REQ-021 Outputs SHALL be undefined until the first rising clk with rst_n=0.

Configuration
REQ-022 When macro HALF_ADDER_STATS_EN is defined, the block SHALL add output port carry_count (CNT_W bits), counting accepted inputs whose result has any_carry=1.
REQ-023 carry_count SHALL increment one cycle after capture, together with out_valid, and SHALL saturate at all-ones without wrapping.
REQ-024 When HALF_ADDER_STATS_EN is not defined, port carry_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 A package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants and the saturation max-value function.
REQ-026 A combinational sub-module half_adder_cell (1-bit a,b -> sum,carry) SHALL be instantiated WIDTH times via generate; all registers SHALL live in half_adder.

Verification
REQ-027 WIDTH=1; after reset, apply (a,b)=00,01,10,11 on consecutive cycles with in_valid=1 -> sum/carry one cycle later = 0/0, 1/0, 1/0, 0/1; out_valid=1 on each of these 4 cycles.
REQ-028 Capture a=1, b=1, then drive in_valid=0 and change a/b for 5 cycles -> sum=0, carry=1 held; out_valid=0.
REQ-029 WIDTH=4; a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000, any_carry=1; then a=4'b0101, b=4'b1010 -> sum=4'b1111, carry=0, any_carry=0.
REQ-030 Assert rst_n=0 while in_valid=1 with a=b=1 -> the following cycle sum=carry=out_valid=0.
REQ-031 HALF_ADDER_STATS_EN defined, CNT_W=4; 20 accepted inputs with a=b=1 -> carry_count reaches 15 and stays 15; reset -> 0.
REQ-032 A randomized bench with 1000 accepted inputs at WIDTH=8 SHALL match a reference model (a^b, a&b) with 1-cycle latency.
